gb_capture_ctrl: RTL
====================

Name: gb_capture_ctrl

Overview:
- Write-side controller for the dual-bank capture framebuffer.
- Synchronises the Game Boy LCD bus (iclk/ihsync/ivsync/idata) into the pixel-clock domain, validates frame geometry, and sequences write address, data and enable into the framebuffer RAM.
- Owns bank arbitration: writes into one bank while the VGA scan-out reads the other. Swaps banks only on a complete, well-formed frame, so scan-out never shows a torn frame.

Parameters:
- H_PIX, 160: pixels per GB line.
- V_LINES, 144: lines per GB frame.
- OFS_W, 15: per-bank offset width. Must satisfy H_PIX*V_LINES <= 2^OFS_W.

Ports:
- clk  in  1  pixel clock (PLL output).
- rst_n  in  1  reset, asynchronous assert, active low.
- en  in  1  capture enable (clk domain).
- idata  in  2  GB pixel data (asynchronous).
- iclk  in  1  GB pixel clock (asynchronous).
- ihsync  in  1  GB line sync (asynchronous).
- ivsync  in  1  GB frame sync (asynchronous).
- wr_addr  out  OFS_W+1  {bank, offset} framebuffer write address.
- wr_data  out  2  framebuffer write data.
- wr_en  out  1  framebuffer write strobe, one cycle per pixel.
- rd_bank  out  1  bank the scan-out must read (last complete frame).
- frame_done  out  1  one-cycle pulse on a good frame plus bank swap.
- frame_err  out  1  one-cycle pulse on a discarded malformed frame.
- capturing  out  1  high while in state CAPTURE.

Behaviour:
- Reset: all outputs 0; rd_bank=0; internal write bank=1; state IDLE; counters 0.
- Synchronisers: iclk, ihsync, ivsync and idata each pass through 2 flops; a third flop gives the rising-edge detect.
  - wr_en rises exactly 3 clk cycles after the first clk edge that samples iclk high.
  - wr_data is the synced idata from the same sample. An iclk high time shorter than 1 clk cycle is not guaranteed.
- FSM:
  - IDLE: en=0. Exit to WAIT_VS when en=1.
  - WAIT_VS: ignore all edges until an ivsync rise, then go to CAPTURE with line=0, px=0, bad=0.
  - CAPTURE: process edges as listed below.
  - en=0 in any state: go to IDLE next cycle. No further wr_en, no swap, no pulses; counters cleared; rd_bank held.
- iclk rise in CAPTURE:
  - If px<H_PIX and line<V_LINES: wr_en=1, offset=line*H_PIX+px, px++.
  - Otherwise: drop the pixel and set bad.
- Offset arithmetic: held as a running line_base register (+H_PIX per line) plus px. No multiplier.
- ihsync rise in CAPTURE:
  - If px==0: ignored (blank line).
  - Else: set bad if px!=H_PIX; then line++ (saturating at V_LINES) and px=0.
- ivsync rise in CAPTURE:
  - Complete frame is line==V_LINES-1 with px==H_PIX, or line==V_LINES with px==0; and bad==0.
  - Complete: frame_done pulse, rd_bank <= write bank, write bank toggles.
  - Otherwise: frame_err pulse and the same bank is reused.
  - Either way, counters and bad are cleared.
- Simultaneous edges in the same cycle:
  - ivsync with anything: ivsync wins; the pixel is dropped and not counted.
  - ihsync with iclk: the hsync is applied first, and the pixel is written as px=0 of the new line.
- Outputs are registered; wr_addr and wr_data are valid only while wr_en=1. frame_done and frame_err are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. The next capture restarts from WAIT_VS.

Decomposition:
- Package gbvga_pkg:
  - state enum {IDLE, WAIT_VS, CAPTURE};
  - GB_H_PIX=160, GB_V_LINES=144 constants;
  - helper constant for the bank-offset width.
- One sub-module, sync_edge: 2FF synchroniser plus rising-edge pulse, with async active-low reset. Instantiated for iclk, ihsync and ivsync; idata uses a plain 2FF bus synchroniser.

Test Plan:
- Reset, then en=1, then one vsync, then 144 lines x 160 iclk pulses with hsync between lines, then vsync -> 23040 wr_en pulses; addresses {1,0}..{1,23039} sequential; frame_done=1 for one cycle; rd_bank=1.
- Second good frame -> writes use bank 0 (wr_addr MSB=0); rd_bank returns to 0; frame_done pulses again.
- Frame with line 10 holding 159 pixels -> frame_err pulse, no frame_done, rd_bank unchanged, next frame rewrites the same bank.
- 161st iclk in a line -> no 161st wr_en; frame ends with frame_err.
- en dropped at line 50 -> within 1 cycle capturing=0 and no wr_en; re-enable -> waits for vsync, and line 0 is written at bank offset 0.
- iclk and ihsync rise together after pixel 160 -> wr_addr offset = next line_base; iclk and ivsync rise together -> no wr_en that cycle.

Source files
------------

// File: rtl/gbvga_pkg.sv
// Shared types and constants for the Game Boy capture path.
// Holds the FSM state type, GB frame geometry and bank-offset width.
package gbvga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int GB_H_PIX   = 160;
  localparam int GB_V_LINES = 144;

  // Smallest per-bank offset width holding one whole frame.
  localparam int GB_OFS_W = $clog2(GB_H_PIX * GB_V_LINES);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// Ports: clk, rst_n, d_i (async level), rise_o (one-cycle pulse).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/gb_capture_ctrl.sv
// Write-side controller of the dual-bank GB capture framebuffer.
// In: clk, rst_n, en, GB bus (idata/iclk/ihsync/ivsync). Out: wr_addr,
// wr_data, wr_en, rd_bank, frame_done, frame_err, capturing.
module gb_capture_ctrl
  import gbvga_pkg::*;
#(
  parameter int H_PIX   = GB_H_PIX,
  parameter int V_LINES = GB_V_LINES,
  parameter int OFS_W   = GB_OFS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       idata,
  input  logic             iclk,
  input  logic             ihsync,
  input  logic             ivsync,
  output logic [OFS_W:0]   wr_addr,
  output logic [1:0]       wr_data,
  output logic             wr_en,
  output logic             rd_bank,
  output logic             frame_done,
  output logic             frame_err,
  output logic             capturing
);

  localparam int PX_W = $clog2(H_PIX + 1);
  localparam int LN_W = $clog2(V_LINES + 1);

  localparam logic [PX_W-1:0]  PX_MAX  = PX_W'(H_PIX);
  localparam logic [LN_W-1:0]  LN_MAX  = LN_W'(V_LINES);
  localparam logic [LN_W-1:0]  LN_LAST = LN_W'(V_LINES - 1);
  localparam logic [OFS_W-1:0] STEP    = OFS_W'(H_PIX);

  logic ck_rise;
  logic hs_rise;
  logic vs_rise;

  sync_edge u_sync_ck (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (iclk),
    .rise_o (ck_rise)
  );

  sync_edge u_sync_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ihsync),
    .rise_o (hs_rise)
  );

  sync_edge u_sync_vs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ivsync),
    .rise_o (vs_rise)
  );

  // Data gets a third stage so it lines up with the registered
  // edge pulse of the iclk sample it belongs to.
  logic [1:0] d1_q;
  logic [1:0] d2_q;
  logic [1:0] d3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= 2'b00;
      d2_q <= 2'b00;
      d3_q <= 2'b00;
    end else begin
      d1_q <= idata;
      d2_q <= d1_q;
      d3_q <= d2_q;
    end
  end

  cap_state_e state_q, state_d;

  logic [PX_W-1:0]  px_q, px_d;
  logic [LN_W-1:0]  line_q, line_d;
  logic [OFS_W-1:0] base_q, base_d;
  logic             bad_q, bad_d;
  logic             wbank_q, wbank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             wr_en_q, wr_en_d;
  logic [OFS_W:0]   wr_addr_q, wr_addr_d;
  logic [1:0]       wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [PX_W-1:0]  px_n;
  logic [LN_W-1:0]  line_n;
  logic [OFS_W-1:0] base_n;
  logic             bad_n;
  logic             frame_ok;

  // Last line ended either by vsync directly or by a trailing hsync.
  assign frame_ok = !bad_q &&
                    ((line_q == LN_LAST && px_q == PX_MAX) ||
                     (line_q == LN_MAX && px_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      px_q      <= '0;
      line_q    <= '0;
      base_q    <= '0;
      bad_q     <= 1'b0;
      wbank_q   <= 1'b1;
      rd_bank_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      line_q    <= line_d;
      base_q    <= base_d;
      bad_q     <= bad_d;
      wbank_q   <= wbank_d;
      rd_bank_q <= rd_bank_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    line_d    = line_q;
    base_d    = base_q;
    bad_d     = bad_q;
    wbank_d   = wbank_q;
    rd_bank_d = rd_bank_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    px_n      = px_q;
    line_n    = line_q;
    base_n    = base_q;
    bad_n     = bad_q;

    if (!en) begin
      state_d = IDLE;
      px_d    = '0;
      line_d  = '0;
      base_d  = '0;
      bad_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_VS;

        WAIT_VS: begin
          if (vs_rise) begin
            state_d = CAPTURE;
            px_d    = '0;
            line_d  = '0;
            base_d  = '0;
            bad_d   = 1'b0;
          end
        end

        CAPTURE: begin
          if (vs_rise) begin
            // vsync wins over any coincident pixel or hsync.
            px_d   = '0;
            line_d = '0;
            base_d = '0;
            bad_d  = 1'b0;
            if (frame_ok) begin
              done_d    = 1'b1;
              rd_bank_d = wbank_q;
              wbank_d   = ~wbank_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // hsync first so a coincident pixel lands on the new line.
            if (hs_rise && px_q != '0) begin
              if (px_q != PX_MAX) bad_n = 1'b1;
              if (line_q != LN_MAX) begin
                line_n = line_q + 1'b1;
                base_n = base_q + STEP;
              end
              px_n = '0;
            end
            if (ck_rise) begin
              if (px_n < PX_MAX && line_n < LN_MAX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {wbank_q, base_n + OFS_W'(px_n)};
                wr_data_d = d3_q;
                px_n      = px_n + 1'b1;
              end else begin
                bad_n = 1'b1;
              end
            end
            px_d   = px_n;
            line_d = line_n;
            base_d = base_n;
            bad_d  = bad_n;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_bank    = rd_bank_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign capturing  = (state_q == CAPTURE);

endmodule
